debug_regbank: RTL
==================

Name: debug_regbank

Overview:
- Parametrised debug register bank on the uartcon_ctrl user bus (U_WRITE/U_READ/U_ADRS/U_WDATA/U_RDATA).
- Successor to the single-LED-register debug top. Provides:
  - NUM_OUT read/write output registers
  - a synchronised input port with readback
  - W1C sticky rising-edge capture with a masked IRQ
  - an ID register
  - a host-activity watchdog that reverts outputs to reset values when the host goes silent
- Sits between uartcon_ctrl and board-level LEDs, GPIOs and status lines.

Parameters:
- NUM_OUT, 4, number of output registers (1..32)
- OUT_W, 8, width of each output register (1..32)
- IN_W, 8, width of IN_DATA (1..32)
- BASE, 32'h0000_0000, byte base address of the bank (must be 256-byte aligned)
- OUT_RESET, 32'h0000_0000, reset/revert value for every output register (low OUT_W bits used)
- ID_VALUE, 32'hDB60_0002, value returned by the ID register

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous active-high reset
- U_WRITE  in  1  single-cycle write strobe
- U_READ  in  1  single-cycle read strobe
- U_ADRS  in  32  byte address
- U_WDATA  in  32  write data
- U_RDATA  out  32  read data, registered
- OUT_DATA  out  NUM_OUT*OUT_W  concatenated output registers; OUT[i] occupies bits [i*OUT_W +: OUT_W]
- IN_DATA  in  IN_W  external inputs, asynchronous to CLK
- IRQ  out  1  registered OR of (STICKY & MASK)

Behaviour:
- Reset: one clock, synchronous active-high (RST). The clock port is CLK; RST=1 sampled on a CLK rising edge resets the block.
- Values after reset:
  - every OUT[i] = OUT_RESET[OUT_W-1:0]
  - U_RDATA = 0, IRQ = 0, STICKY = 0, MASK = 0, WDOG_LOAD = 0 (watchdog disabled), STATUS = 0
  - synchroniser and edge history = 0
- Address map (offset from BASE, exact 32-bit match, U_ADRS[1:0] must be 0):
  - 0x00 + 4*i: OUT[i], RW
  - 0x80: IN, RO
  - 0x84: STICKY, W1C
  - 0x88: MASK, RW
  - 0x8C: ID, RO
  - 0x90: WDOG_LOAD, RW
  - 0x94: STATUS, bit0 = watchdog expired, W1C
- Unmapped or RO writes are ignored. Unmapped reads return 0. Narrow registers zero-extend on read and truncate on write.
- Read latency: U_RDATA updates on the edge that samples U_READ and holds until the next U_READ.
- U_WRITE and U_READ in the same cycle: both execute; the read returns the pre-write value.
- Input path: IN_DATA passes through a 2-flop synchroniser to IN_S, plus one history register.
  - Rising edge = IN_S & ~IN_prev.
  - STICKY bit sets 3 cycles after the input rises.
  - Same-cycle set and W1C clear: set wins.
- IRQ is registered: asserts 1 cycle after STICKY & MASK becomes non-zero.
- Watchdog states:
  - IDLE: WDOG_LOAD == 0; counter held at 0.
  - RUN: counter reloads to WDOG_LOAD on any U_WRITE or U_READ, otherwise decrements by 1.
    - At 1 -> 0, move to EXPIRED on the next cycle: every OUT[i] reverts to OUT_RESET and STATUS[0] sets.
  - EXPIRED: counter held; any bus access reloads the counter and returns to RUN.
  - Writing WDOG_LOAD = 0 from any state goes to IDLE.
- Expiry coinciding with an OUT write: the write wins for that register; the revert is suppressed for the whole cycle because the access also reloads the counter.
- Counter width is 32 bits; no wrap, since decrement stops at 0.
- Reset mid-operation aborts everything, including a pending read.

Optional Feature:
- Macro: DEBUG_REGBANK_IN_SYNC_EN.
- Defined: 2-flop synchroniser as above; sticky latency is 3 cycles.
- Undefined: IN_DATA is registered once, for same-clock sources; IN readback latency is 1 cycle and sticky latency is 2 cycles.

Decomposition:
- Package debug_regbank_pkg holds:
  - register offset constants (OFS_OUT0, OFS_IN, OFS_STICKY, OFS_MASK, OFS_ID, OFS_WDOG, OFS_STATUS)
  - default ID constant
  - 2-bit watchdog state typedef (IDLE, RUN, EXPIRED)
- Sub-module debug_regbank_wdog: counter plus FSM.
  - Inputs: CLK, RST, load value, access strobe, load-write strobe.
  - Output: single-cycle expire pulse.

Test Plan:
- Reset with defaults -> OUT_DATA = 0, U_RDATA = 0, IRQ = 0. Read 0x8C -> U_RDATA = 0xDB60_0002 on the next cycle.
- Write 0x08 = 0x1A5 with OUT_W = 8 -> OUT[2] = 0xA5. Read 0x08 -> 0x0000_00A5. Read 0x40 -> 0.
- Raise IN_DATA[3] -> STICKY = 0x08 after 3 cycles. Write MASK = 0x08 -> IRQ = 1. Write 0x84 = 0x08 in the same cycle as a new edge on bit 3 -> STICKY stays 0x08.
- WDOG_LOAD = 10, then no access -> OUT revert to OUT_RESET and STATUS = 1 at cycle 11. Read 0x94 -> 1. Write 0x94 = 1 -> STATUS = 0.
- WDOG_LOAD = 10 with U_READ every 8 cycles -> no expiry over 1000 cycles.
- Same-cycle write 0x00 = 0x55 and read 0x00 (prior value 0x11) -> U_RDATA = 0x11, OUT[0] = 0x55. Assert RST mid-sequence -> all outputs reset on the next edge.

Source files
------------

// File: rtl/debug_regbank_pkg.sv
// Shared constants for the debug register bank: register offsets, default ID
// and the watchdog state encoding.
package debug_regbank_pkg;

  localparam logic [7:0] OFS_OUT0   = 8'h00;
  localparam logic [7:0] OFS_IN     = 8'h80;
  localparam logic [7:0] OFS_STICKY = 8'h84;
  localparam logic [7:0] OFS_MASK   = 8'h88;
  localparam logic [7:0] OFS_ID     = 8'h8C;
  localparam logic [7:0] OFS_WDOG   = 8'h90;
  localparam logic [7:0] OFS_STATUS = 8'h94;

  localparam logic [31:0] DEFAULT_ID = 32'hDB60_0002;

  typedef logic [1:0] wdog_state_t;
  localparam wdog_state_t WD_IDLE    = 2'd0;
  localparam wdog_state_t WD_RUN     = 2'd1;
  localparam wdog_state_t WD_EXPIRED = 2'd2;

endpackage

// File: rtl/debug_regbank_wdog.sv
// Host-activity watchdog: counts down from the load value between bus accesses
// and emits a one-cycle expire pulse when the host has gone silent.
module debug_regbank_wdog
  import debug_regbank_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] load,
  input  logic        access,
  input  logic        load_wr,
  output logic        expire
);

  wdog_state_t state;
  logic [31:0] cnt;

  // Any access in the would-be expiry cycle reloads instead, so the revert never
  // races a bus write.
  assign expire = (state == WD_RUN) && (cnt == 32'd0) && !access;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= WD_IDLE;
      cnt   <= 32'd0;
    end else if (load_wr && (load == 32'd0)) begin
      state <= WD_IDLE;
      cnt   <= 32'd0;
    end else begin
      case (state)
        WD_IDLE: begin
          if (load_wr) begin
            state <= WD_RUN;
            cnt   <= load;
          end
        end
        WD_RUN: begin
          if (access) begin
            cnt <= load;
          end else if (cnt == 32'd0) begin
            state <= WD_EXPIRED;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        WD_EXPIRED: begin
          if (access) begin
            state <= WD_RUN;
            cnt   <= load;
          end
        end
        default: begin
          state <= WD_IDLE;
          cnt   <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: rtl/debug_regbank.sv
// Debug register bank on the uartcon_ctrl user bus: output registers, input
// readback with W1C sticky edge capture and IRQ, ID, and a host watchdog.
// DEBUG_REGBANK_IN_SYNC_EN selects a 2-flop synchroniser on IN_DATA.
module debug_regbank
  import debug_regbank_pkg::*;
#(
  parameter int          NUM_OUT   = 4,
  parameter int          OUT_W     = 8,
  parameter int          IN_W      = 8,
  parameter logic [31:0] BASE      = 32'h0000_0000,
  parameter logic [31:0] OUT_RESET = 32'h0000_0000,
  parameter logic [31:0] ID_VALUE  = DEFAULT_ID
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     U_WRITE,
  input  logic                     U_READ,
  input  logic [31:0]              U_ADRS,
  input  logic [31:0]              U_WDATA,
  output logic [31:0]              U_RDATA,
  output logic [NUM_OUT*OUT_W-1:0] OUT_DATA,
  input  logic [IN_W-1:0]          IN_DATA,
  output logic                     IRQ
);

  localparam logic [5:0] NUM_OUT6 = 6'(NUM_OUT);

  logic [OUT_W-1:0] out_q [NUM_OUT];
  logic [IN_W-1:0]  in_s, in_prev, in_rise, sticky, sticky_clr, mask;
  logic [31:0]      wdog_load, wdog_next, rd_val;
  logic             status, expire, access, wdog_wr;

  logic [7:0] ofs;
  logic [4:0] out_idx;
  logic in_bank, hit_out, wr_out;
  logic sel_in, sel_sticky, sel_mask, sel_id, sel_wdog, sel_status;

  // BASE is 256-byte aligned, so the page compare plus the low byte is an exact match.
  assign ofs        = U_ADRS[7:0];
  assign in_bank    = (U_ADRS[31:8] == BASE[31:8]) && (U_ADRS[1:0] == 2'b00);
  assign out_idx    = ofs[6:2];
  assign hit_out    = in_bank && (ofs < OFS_IN) && ({1'b0, out_idx} < NUM_OUT6);
  assign sel_in     = in_bank && (ofs == OFS_IN);
  assign sel_sticky = in_bank && (ofs == OFS_STICKY);
  assign sel_mask   = in_bank && (ofs == OFS_MASK);
  assign sel_id     = in_bank && (ofs == OFS_ID);
  assign sel_wdog   = in_bank && (ofs == OFS_WDOG);
  assign sel_status = in_bank && (ofs == OFS_STATUS);

  assign wr_out     = U_WRITE && hit_out;
  assign wdog_wr    = U_WRITE && sel_wdog;
  assign access     = U_WRITE || U_READ;
  assign sticky_clr = (U_WRITE && sel_sticky) ? U_WDATA[IN_W-1:0] : '0;
  assign in_rise    = in_s & ~in_prev;

`ifdef DEBUG_REGBANK_IN_SYNC_EN
  logic [IN_W-1:0] in_meta;
  always_ff @(posedge CLK) begin
    if (RST) begin
      in_meta <= '0;
      in_s    <= '0;
    end else begin
      in_meta <= IN_DATA;
      in_s    <= in_meta;
    end
  end
`else
  always_ff @(posedge CLK) begin
    if (RST) in_s <= '0;
    else     in_s <= IN_DATA;
  end
`endif

  // A write to WDOG_LOAD must reload with the new value, not the old register.
  assign wdog_next = wdog_wr ? U_WDATA : wdog_load;

  debug_regbank_wdog u_wdog (
    .CLK     (CLK),
    .RST     (RST),
    .load    (wdog_next),
    .access  (access),
    .load_wr (wdog_wr),
    .expire  (expire)
  );

  always_comb begin
    rd_val = '0;
    if (hit_out) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (out_idx == 5'(i)) rd_val[OUT_W-1:0] = out_q[i];
      end
    end else if (sel_in) begin
      rd_val[IN_W-1:0] = in_s;
    end else if (sel_sticky) begin
      rd_val[IN_W-1:0] = sticky;
    end else if (sel_mask) begin
      rd_val[IN_W-1:0] = mask;
    end else if (sel_id) begin
      rd_val = ID_VALUE;
    end else if (sel_wdog) begin
      rd_val = wdog_load;
    end else if (sel_status) begin
      rd_val[0] = status;
    end
  end

  always_comb begin
    OUT_DATA = '0;
    for (int i = 0; i < NUM_OUT; i++) OUT_DATA[i*OUT_W +: OUT_W] = out_q[i];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_OUT; i++) out_q[i] <= OUT_RESET[OUT_W-1:0];
      in_prev   <= '0;
      sticky    <= '0;
      mask      <= '0;
      wdog_load <= '0;
      status    <= 1'b0;
      IRQ       <= 1'b0;
      U_RDATA   <= '0;
    end else begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (wr_out && (out_idx == 5'(i))) out_q[i] <= U_WDATA[OUT_W-1:0];
        else if (expire)                   out_q[i] <= OUT_RESET[OUT_W-1:0];
      end
      in_prev <= in_s;
      // A new edge in the same cycle as its W1C clear stays captured.
      sticky  <= (sticky & ~sticky_clr) | in_rise;
      if (U_WRITE && sel_mask) mask      <= U_WDATA[IN_W-1:0];
      if (wdog_wr)             wdog_load <= U_WDATA;
      if (expire)                                   status <= 1'b1;
      else if (U_WRITE && sel_status && U_WDATA[0]) status <= 1'b0;
      IRQ <= |(sticky & mask);
      if (U_READ) U_RDATA <= rd_val;
    end
  end

endmodule
